// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: computes a - b - bin modulo 2^WIDTH one bit per
// cycle, LSB first, through a single full-subtractor slice. Results and
// status flags are registered and only change when an operation completes.
module serial_subtractor_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;

    // Full-subtractor slice on the current LSBs, plus the result word as it
    // will look once this bit is shifted in from the top.
    always_comb begin
        ai      = sa[0];
        bi      = sb[0];
        d       = ai ^ bi ^ br;
        br_next = (~ai & bi) | (~(ai ^ bi) & br);
        sr_next = {d, sr[WIDTH-1:1]};
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        sr    <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sr <= sr_next;
                    br <= br_next;
                    if (cnt == LAST) begin
                        // Last bit: publish the whole word and final borrow at once.
                        cnt   <= '0;
                        diff  <= sr_next;
                        bout  <= br_next;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: an arithmetic reference
// model is compared against the DUT every cycle, plus directed literal checks.
module tb_serial_subtractor_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference model: result = a - b - bin computed arithmetically at accept
    // time, busy for W cycles afterwards, then done with that result.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_bout = 1'b0;
    int           m_left = 0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        int dv;
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_left = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (start) begin
                    dv     = int'(a) - int'(b) - int'(bin);
                    p_diff = W'(dv);
                    p_bout = (int'(a) < int'(b) + int'(bin));
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    m_left = W;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_diff = p_diff;
                    m_bout = p_bout;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks += 5;
            if (busy !== m_busy) begin n_fail++; $display("FAIL cyc_busy t=%0t got %b exp %b", $time, busy, m_busy); end
            if (done !== m_done) begin n_fail++; $display("FAIL cyc_done t=%0t got %b exp %b", $time, done, m_done); end
            if (diff !== m_diff) begin n_fail++; $display("FAIL cyc_diff t=%0t got %0d exp %0d", $time, diff, m_diff); end
            if (bout !== m_bout) begin n_fail++; $display("FAIL cyc_bout t=%0t got %b exp %b", $time, bout, m_bout); end
            if ((busy & done) !== 1'b0) begin n_fail++; $display("FAIL busy_and_done t=%0t got %b exp 0", $time, busy & done); end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Wait (bounded) for done, counting busy-high and done-low cycles seen.
    task automatic wait_done(output int nbusy, output int nlow);
        bit seen = 1'b0;
        nbusy = 0;
        nlow  = 0;
        for (int k = 0; k < 4 * W + 8; k++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            if (busy === 1'b1) nbusy++;
            nlow++;
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout got 0 exp 1");
        end
    endtask

    // Pulse start for one cycle, scramble inputs during RUN, wait for result.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      output int nbusy, output int nlow);
        rst   = 1'b0;
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        wait_done(nbusy, nlow);
    endtask

    initial begin
        int nb;
        int nl;
        rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd1; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_diff", int'(diff), 0);
        check("reset_bout", int'(bout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // First edge with rst low and start high is accepted.
        op(4'd9, 4'd3, 1'b0, nb, nl);
        check("r26_busy_cycles", nb, 4);
        check("r26_diff", int'(diff), 6);
        check("r26_bout", int'(bout), 0);

        op(4'd3, 4'd9, 1'b0, nb, nl);
        check("r27_diff", int'(diff), 10);
        check("r27_bout", int'(bout), 1);

        op(4'd0, 4'd0, 1'b1, nb, nl);
        check("r28a_diff", int'(diff), 15);
        check("r28a_bout", int'(bout), 1);
        op(4'd15, 4'd15, 1'b1, nb, nl);
        check("r28b_done_low", nl, 4);
        check("r28b_diff", int'(diff), 15);
        check("r28b_bout", int'(bout), 1);

        // Start re-asserted during RUN must be ignored.
        start = 1'b1; a = 4'd7; b = 4'd2; bin = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd5;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, nl);
        check("r29_diff", int'(diff), 5);
        check("r29_bout", int'(bout), 0);
        repeat (W + 2) @(negedge clk);
        check("r29_no_second", int'(busy), 0);
        check("r29_done_held", int'(done), 1);
        check("r29_diff_held", int'(diff), 5);

        // Reset on the second RUN cycle aborts the operation.
        start = 1'b1; a = 4'd12; b = 4'd4; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("r30_busy", int'(busy), 0);
        check("r30_done", int'(done), 0);
        check("r30_diff", int'(diff), 0);
        check("r30_bout", int'(bout), 0);
        rst = 1'b0;
        repeat (W + 1) @(negedge clk);
        check("r30_no_late_result", int'(done), 0);
        op(4'd12, 4'd4, 1'b1, nb, nl);
        check("r30b_diff", int'(diff), 7);
        check("r30b_bout", int'(bout), 0);

        // Exhaustive sweep, back to back; per-cycle model compares each result.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            op(v[8:5], v[4:1], v[0], nb, nl);
        end

        start = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits, valid for WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  minuend; captured on accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 bin  input  1  borrow-in; captured on accepted start.
REQ-008 diff  output  WIDTH  registered result, a - b - bin modulo 2^WIDTH.
REQ-009 bout  output  1  registered borrow-out, 1 iff a < b + bin (unsigned).
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  high for the cycle(s) the FSM is in DONE; result valid.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: busy=0, done=0; start=1 -> capture a, b, bin into internal shift registers, clear bit counter, go to RUN.
REQ-014 RUN: busy=1, done=0; each cycle SHALL process one bit LSB first via a single full-subtractor slice: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-015 RUN SHALL last exactly WIDTH cycles; bit counter wraps from WIDTH-1 to exit, no extra cycle.
REQ-016 On leaving RUN, diff and bout SHALL be loaded together from the completed internal result; FSM goes to DONE.
REQ-017 diff and bout SHALL hold their previous values throughout RUN (no partial results visible).
REQ-018 DONE: busy=0, done=1; start=0 -> stay in DONE holding results; start=1 -> capture new operands, go to RUN, done drops next cycle.
REQ-019 Latency: start sampled high at edge N (from IDLE/DONE) -> busy high from N+1 to N+WIDTH, done and new diff/bout visible after edge N+WIDTH+1.
REQ-020 start while in RUN SHALL be ignored; operands and a, b, bin input changes during RUN SHALL not affect the result.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH; all-ones minus all-ones with bin=1 yields all-ones diff, bout=1.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, diff=0, bout=0, busy=0, done=0, clear shift registers and counter, overriding start.
REQ-024 rst asserted mid-RUN SHALL abort the operation; no result is ever loaded from the aborted operation.
REQ-025 First start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-026 a=9, b=3, bin=0, start 1 cycle -> busy 4 cycles, then done=1, diff=6, bout=0.
REQ-027 a=3, b=9, bin=0 -> diff=10 (4'hA), bout=1.
REQ-028 a=0, b=0, bin=1 -> diff=15, bout=1; then a=15, b=15, bin=1 with start held in DONE -> diff=15, bout=1, done low for exactly 4 cycles between results.
REQ-029 start pulsed with a=7, b=2, then start re-asserted with a=1, b=5 during RUN -> only diff=5, bout=0 produced; second request ignored.
REQ-030 rst asserted on 2nd RUN cycle of a=12, b=4 -> next cycle busy=0, done=0, diff=0, bout=0; following start with a=12, b=4, bin=1 -> diff=7, bout=0.
REQ-031 Exhaustive: all 512 (a, b, bin) combinations at WIDTH=4 back-to-back -> diff/bout match a - b - bin reference model every done.
